simon_word_loader: RTL

//  Upstream input stage for the SIMON 128/192 core. Assembles W-bit bus words into one 2N-bit plaintext block
//  and one M*N-bit key. Presents each to the core with the newData/newKey -> ldData/ldKey handshake.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/simon_word_packer.sv | 57 +++++
 rtl/simon_word_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON 128/192 host word loader.
// Build option: SIMON_LOADER_DBUF_EN enables the two-entry data channel.
package simon_pkg;

  localparam int P_N = 64;
  localparam int P_M = 3;
  localparam int P_W = 32;

  localparam int DW = (2 * P_N) / P_W;
  localparam int KW = (P_M * P_N) / P_W;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } chan_state_t;

  typedef logic [P_W-1:0] word_t;

  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/simon_word_packer.sv
// One loader channel: slot counter, word register and FILL/PEND handshake.
// Build option: none (see SIMON_LOADER_DBUF_EN in the top).
module simon_word_packer
  import simon_pkg::*;
#(
  parameter int W     = 32,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               R,
  input  logic               i_wr,
  input  logic [W-1:0]       i_data,
  input  logic               i_ld,
  output logic               o_ready,
  output logic               o_new,
  output logic [W*WORDS-1:0] o_vec
);

  localparam int CW = cnt_w(WORDS);

  chan_state_t        r_state;
  chan_state_t        w_next;
  logic [CW-1:0]      r_cnt;
  logic [W*WORDS-1:0] r_vec;
  logic               w_last;
  logic               w_take;

  assign w_last  = (r_cnt == CW'(WORDS - 1));
  assign w_take  = i_wr && (r_state == FILL);
  assign o_ready = (r_state == FILL);
  assign o_new   = (r_state == PEND);
  assign o_vec   = r_vec;

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_vec[W*int'(r_cnt) +: W] <= i_data;
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FILL: if (w_take && w_last) w_next = PEND;
      PEND: if (i_ld) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

endmodule

// File: rtl/simon_word_loader.sv
// Host-bus to SIMON core loader: packs W-bit words into plain block and key.
// Build option: SIMON_LOADER_DBUF_EN makes the data channel ping-pong.
module simon_word_loader
  import simon_pkg::*;
#(
  parameter int N = P_N,
  parameter int M = P_M,
  parameter int W = P_W
) (
  input  logic                clk,
  input  logic                R,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                wr_sel,
  input  logic                wr_mode,
  input  logic [W-1:0]        wr_data,
  output logic [2*N-1:0]      plain,
  output logic [M-1:0][N-1:0] key,
  output logic                enc_dec,
  output logic                newData,
  output logic                newKey,
  input  logic                ldData,
  input  logic                ldKey
);

  localparam int DWORDS = (2 * N) / W;
  localparam int KWORDS = (M * N) / W;

  logic             w_drdy;
  logic             w_krdy;
  logic             w_dwr;
  logic             w_kwr;
  logic [M*N-1:0]   w_kvec;

  assign wr_ready = wr_sel ? w_krdy : w_drdy;
  assign w_dwr    = wr_valid && wr_ready && !wr_sel;
  assign w_kwr    = wr_valid && wr_ready && wr_sel;
  assign key      = w_kvec;

  simon_word_packer #(.W(W), .WORDS(KWORDS)) u_key (
    .clk     (clk),
    .R       (R),
    .i_wr    (w_kwr),
    .i_data  (wr_data),
    .i_ld    (ldKey),
    .o_ready (w_krdy),
    .o_new   (newKey),
    .o_vec   (w_kvec)
  );

`ifdef SIMON_LOADER_DBUF_EN
  logic           r_wp;
  logic           r_rp;
  logic           w_wp;
  logic [1:0]     r_mid;
  logic [1:0]     r_mode;
  logic [1:0]     w_rdy;
  logic [1:0]     w_new;
  logic [2*N-1:0] w_vec [2];

  // Skip past an entry that just went PEND so the bus never sees a gap.
  assign w_wp    = r_wp ^ w_new[r_wp];
  assign w_drdy  = w_rdy[w_wp];
  assign plain   = w_vec[r_rp];
  assign newData = w_new[r_rp];
  assign enc_dec = r_mode[r_rp];

  for (genvar g = 0; g < 2; g++) begin : g_dbuf
    simon_word_packer #(.W(W), .WORDS(DWORDS)) u_data (
      .clk     (clk),
      .R       (R),
      .i_wr    (w_dwr && (w_wp == 1'(g))),
      .i_data  (wr_data),
      .i_ld    (ldData && (r_rp == 1'(g))),
      .o_ready (w_rdy[g]),
      .o_new   (w_new[g]),
      .o_vec   (w_vec[g])
    );
  end

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_mid  <= '0;
      r_mode <= '0;
    end else begin
      if (w_rdy[w_wp]) r_wp <= w_wp;
      if (ldData && w_new[r_rp]) r_rp <= ~r_rp;
      for (int i = 0; i < 2; i++) begin
        if (w_dwr && (w_wp == 1'(i))) begin
          r_mid[i] <= 1'b1;
          if (!r_mid[i]) r_mode[i] <= wr_mode;
        end else if (w_new[i]) begin
          r_mid[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic r_mid;
  logic r_mode;

  assign enc_dec = r_mode;

  simon_word_packer #(.W(W), .WORDS(DWORDS)) u_data (
    .clk     (clk),
    .R       (R),
    .i_wr    (w_dwr),
    .i_data  (wr_data),
    .i_ld    (ldData),
    .o_ready (w_drdy),
    .o_new   (newData),
    .o_vec   (plain)
  );

  // r_mid marks a block in progress; mode is taken only on its first word.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      r_mid  <= 1'b0;
      r_mode <= 1'b0;
    end else if (w_dwr) begin
      r_mid <= 1'b1;
      if (!r_mid) r_mode <= wr_mode;
    end else if (newData) begin
      r_mid <= 1'b0;
    end
  end
`endif

endmodule
